param_cpu_core: RTL
===================

# param_cpu_core

Parametrised single-cycle accumulator CPU core: the next generation of the team's 4-bit CPU, generalised in data width and program-counter width. It adds a carry flag, a conditional jump, an input port, an instruction-valid stall handshake and a halt state. It sits between an asynchronous-read program ROM (driven by `PC`, returning `INSTR`) and board-level I/O (`IN_PORT`, `OUT`).

## Interface

Parameters:
- `DATA_W`, default 4: register, ALU, immediate and I/O width; must be ≥ 2.
- `PC_W`, default 4: program-counter width; must be ≤ `DATA_W`.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `RST`, in, 1: asynchronous, active-low reset.
- `INSTR`, in, `4+DATA_W`: instruction. Bits `[DATA_W+3:DATA_W]` are the opcode; bits `[DATA_W-1:0]` are the immediate `Im`.
- `INSTR_VALID`, in, 1: `INSTR` is valid for the current `PC`.
- `IN_PORT`, in, `DATA_W`: input port, sampled by IN instructions.
- `PC`, out, `PC_W`: program counter, registered.
- `OUT`, out, `DATA_W`: output port, registered.
- `CARRY`, out, 1: carry flag, registered.
- `HALTED`, out, 1: core is halted, registered.
- `RETIRE`, out, 1: registered pulse, high for one cycle after each executed instruction.

## Operation

- Internal state: registers `A` and `B` (`DATA_W` each), `PC`, `CARRY`, `OUT`, `HALTED`.
- An instruction executes on a rising edge only when `INSTR_VALID`=1 and `HALTED`=0. Otherwise all state holds and `RETIRE` is driven 0.
- Opcodes, where `PC+1` is the default next PC and `C` is the new carry:
  - `0000` ADD A,Im: `A←A+Im`, `C`=carry-out.
  - `0001` MOV A,B.
  - `0010` IN A: `A←IN_PORT`.
  - `0011` MOV A,Im.
  - `0100` MOV B,A.
  - `0101` ADD B,Im: `B←B+Im`, `C`=carry-out.
  - `0110` IN B.
  - `0111` MOV B,Im.
  - `1001` OUT B: `OUT←B`.
  - `1011` OUT Im: `OUT←Im`.
  - `1010` HALT: `HALTED←1`, `PC` holds.
  - `1110` JNC Im: if `CARRY`=0 then `PC←Im[PC_W-1:0]`, else `PC+1`.
  - `1111` JMP Im: `PC←Im[PC_W-1:0]`.
  - All other opcodes: NOP, `PC+1`.
- Carry rule: every executed instruction writes `CARRY`. ADD writes its carry-out; every other opcode, including JNC, HALT and NOP, writes 0. JNC tests the carry value produced by the previously executed instruction.
- Arithmetic is modulo 2^`DATA_W`. `PC+1` wraps modulo 2^`PC_W`: all-ones goes to 0.
- MOV with a register source uses the pre-edge value, so MOV A,B followed by MOV B,A leaves `A`=`B`.
- Halt: `HALTED` is sticky. Only `RST` clears it. While halted, `INSTR` and `INSTR_VALID` are ignored.

## Timing

- Reset value while `RST`=0, asserted asynchronously: `PC`=0, `A`=0, `B`=0, `CARRY`=0, `OUT`=0, `HALTED`=0, `RETIRE`=0.
- The first fetch is at `PC`=0 in the first cycle after `RST` deasserts.
- Latency: one cycle per instruction. `INSTR` is combinational from `PC` (asynchronous ROM) and is sampled at the next edge. The results in `A`, `B`, `OUT`, `CARRY` and `PC` are visible in the same cycle that `RETIRE`=1.
- Throughput: one instruction per cycle with `INSTR_VALID` held at 1.
- `OUT` updates on the edge that executes OUT. There is no extra output register stage.
- Stall: `INSTR_VALID`=0 for N cycles inserts exactly N idle cycles, with no architectural change.
- Reset mid-operation: asynchronous clear of all state. There is no partial write.

## Structure

- Shared package `cpu_pkg`: opcode localparams (`OP_ADD_A`, …, `OP_JMP`), opcode width 4, and the decoded-control struct (destination select, source select, load enables, jump type, halt).
- Natural sub-module `cpu_decoder`: purely combinational, maps opcode to the control struct.
- The core holds the datapath, the registers and the next-PC logic.

## Test plan

- Reset, then ROM `{MOV A,3; ADD A,2; OUT Im 5}` with `DATA_W`=4 → `A`=5 after cycle 2, `OUT`=5 after cycle 3, `RETIRE` high in 3 cycles, `CARRY`=0.
- `MOV A,15; ADD A,1; JNC 0; OUT Im 9` → `A`=0, `CARRY`=1, JNC not taken, `OUT`=9. Repeat with ADD A,0 → JNC taken to `PC`=0.
- `PC_W`=4, ROM of 16 NOPs → `PC` wraps 15→0; `JMP 7` then sets `PC`=7.
- `INSTR_VALID` low for 3 cycles mid-program → `PC`, `A`, `B`, `OUT` and `CARRY` frozen, `RETIRE`=0 for exactly those 3 cycles.
- `HALT` at `PC`=2 → `HALTED`=1, `PC` stays 2 indefinitely. `RST` pulse clears it and execution restarts at `PC`=0.
- `DATA_W`=8, `PC_W`=6: `IN A` with `IN_PORT`=0xF0, `ADD A,0x20` → `A`=0x10, `CARRY`=1. `JMP 0xFF` → `PC`=63.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode encodings and the decoded control word.
package cpu_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_ADD_A  = 4'b0000;
   localparam logic [OP_W-1:0] OP_MOV_AB = 4'b0001;
   localparam logic [OP_W-1:0] OP_IN_A   = 4'b0010;
   localparam logic [OP_W-1:0] OP_MOV_AI = 4'b0011;
   localparam logic [OP_W-1:0] OP_MOV_BA = 4'b0100;
   localparam logic [OP_W-1:0] OP_ADD_B  = 4'b0101;
   localparam logic [OP_W-1:0] OP_IN_B   = 4'b0110;
   localparam logic [OP_W-1:0] OP_MOV_BI = 4'b0111;
   localparam logic [OP_W-1:0] OP_OUT_B  = 4'b1001;
   localparam logic [OP_W-1:0] OP_HALT   = 4'b1010;
   localparam logic [OP_W-1:0] OP_OUT_I  = 4'b1011;
   localparam logic [OP_W-1:0] OP_JNC    = 4'b1110;
   localparam logic [OP_W-1:0] OP_JMP    = 4'b1111;

   typedef enum logic {DstA, DstB} dst_e;
   typedef enum logic [1:0] {SrcImm, SrcA, SrcB, SrcIn} src_e;
   typedef enum logic [1:0] {JmpNone, JmpNc, JmpAlways} jmp_e;

   typedef struct packed {
      dst_e dst;     // register written by reg_we, also the ADD operand
      src_e src;     // value moved into dst or OUT
      logic reg_we;
      logic add;     // dst <- dst + Im instead of src
      logic out_we;
      jmp_e jmp;
      logic halt;
   } ctrl_t;

endpackage

// File: rtl/cpu_decoder.sv
// Purely combinational opcode decoder for param_cpu_core.
module cpu_decoder import cpu_pkg::*; (
   input  logic [OP_W-1:0] opcode,
   output ctrl_t           ctrl
);

   always_comb begin
      ctrl        = '0;
      ctrl.dst    = DstA;
      ctrl.src    = SrcImm;
      ctrl.jmp    = JmpNone;
      case (opcode)
         OP_ADD_A:  begin ctrl.reg_we = 1'b1; ctrl.add = 1'b1; end
         OP_MOV_AB: begin ctrl.reg_we = 1'b1; ctrl.src = SrcB; end
         OP_IN_A:   begin ctrl.reg_we = 1'b1; ctrl.src = SrcIn; end
         OP_MOV_AI: begin ctrl.reg_we = 1'b1; end
         OP_MOV_BA: begin ctrl.reg_we = 1'b1; ctrl.dst = DstB; ctrl.src = SrcA; end
         OP_ADD_B:  begin ctrl.reg_we = 1'b1; ctrl.dst = DstB; ctrl.add = 1'b1; end
         OP_IN_B:   begin ctrl.reg_we = 1'b1; ctrl.dst = DstB; ctrl.src = SrcIn; end
         OP_MOV_BI: begin ctrl.reg_we = 1'b1; ctrl.dst = DstB; end
         OP_OUT_B:  begin ctrl.out_we = 1'b1; ctrl.src = SrcB; end
         OP_OUT_I:  begin ctrl.out_we = 1'b1; end
         OP_HALT:   ctrl.halt = 1'b1;
         OP_JNC:    ctrl.jmp  = JmpNc;
         OP_JMP:    ctrl.jmp  = JmpAlways;
         default:   ;
      endcase
   end

endmodule

// File: rtl/param_cpu_core.sv
// Parametrised single-cycle accumulator core: A/B registers, carry, conditional jump,
// input port, instruction-valid stall and sticky halt.
module param_cpu_core import cpu_pkg::*; #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned PC_W   = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [DATA_W+3:0]    INSTR,
   input  logic                 INSTR_VALID,
   input  logic [DATA_W-1:0]    IN_PORT,
   output logic [PC_W-1:0]      PC,
   output logic [DATA_W-1:0]    OUT,
   output logic                 CARRY,
   output logic                 HALTED,
   output logic                 RETIRE
);

   logic [OP_W-1:0]   opcode;
   logic [DATA_W-1:0] imm;
   ctrl_t             ctrl;

   logic [DATA_W-1:0] a_q, b_q, out_q;
   logic [PC_W-1:0]   pc_q;
   logic              carry_q, halted_q, retire_q;

   logic              exec;
   logic [DATA_W-1:0] src_val, dst_val, wr_val;
   logic [DATA_W:0]   sum;
   logic [PC_W-1:0]   pc_inc, pc_next;

   assign opcode = INSTR[DATA_W+3:DATA_W];
   assign imm    = INSTR[DATA_W-1:0];

   cpu_decoder u_decoder (
      .opcode (opcode),
      .ctrl   (ctrl)
   );

   assign exec = INSTR_VALID && !halted_q;

   always_comb begin
      src_val = imm;
      case (ctrl.src)
         SrcImm:  src_val = imm;
         SrcA:    src_val = a_q;
         SrcB:    src_val = b_q;
         SrcIn:   src_val = IN_PORT;
         default: src_val = imm;
      endcase
   end

   assign dst_val = (ctrl.dst == DstB) ? b_q : a_q;
   assign sum     = {1'b0, dst_val} + {1'b0, imm};
   assign wr_val  = ctrl.add ? sum[DATA_W-1:0] : src_val;
   assign pc_inc  = pc_q + PC_W'(1);

   // JNC looks at the carry left by the previously executed instruction.
   always_comb begin
      pc_next = pc_inc;
      case (ctrl.jmp)
         JmpNone:   pc_next = ctrl.halt ? pc_q : pc_inc;
         JmpNc:     pc_next = carry_q ? pc_inc : imm[PC_W-1:0];
         JmpAlways: pc_next = imm[PC_W-1:0];
         default:   pc_next = pc_inc;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         a_q      <= '0;
         b_q      <= '0;
         out_q    <= '0;
         pc_q     <= '0;
         carry_q  <= 1'b0;
         halted_q <= 1'b0;
         retire_q <= 1'b0;
      end else begin
         retire_q <= exec;
         if (exec) begin
            pc_q    <= pc_next;
            carry_q <= ctrl.add & sum[DATA_W];
            if (ctrl.reg_we && ctrl.dst == DstA) a_q <= wr_val;
            if (ctrl.reg_we && ctrl.dst == DstB) b_q <= wr_val;
            if (ctrl.out_we) out_q <= src_val;
            if (ctrl.halt) halted_q <= 1'b1;
         end
      end
   end

   assign PC     = pc_q;
   assign OUT    = out_q;
   assign CARRY  = carry_q;
   assign HALTED = halted_q;
   assign RETIRE = retire_q;

endmodule
